// File: rtl/mux8way_rr_collector.sv
// 8-to-1 round-robin collector: merges eight valid/ready sources into one registered sink stream.
// Latency: a word accepted in cycle N appears on out_* in cycle N+1; 1 word/cycle sustained.
// Backpressure: out_ready low holds the output stage, drops all in_ready and freezes the rr pointer.
module mux8way_rr_collector #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic [2:0] ptr;
  logic [2:0] gnt_idx;
  logic [2:0] idx;
  logic       gnt_vld;
  logic       load;
  logic       xfer;

  assign load = !out_valid || out_ready;

  // Walk from the highest offset down so the channel closest to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 3'd0;
    idx     = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign xfer     = rst_n && load && gnt_vld;
  assign in_ready = xfer ? (8'b1 << gnt_idx) : 8'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
      ptr       <= 3'd0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_sel   <= gnt_idx;
      ptr       <= gnt_idx + 3'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8way_rr_collector.sv
// Directed bench for mux8way_rr_collector: reset, single source, rr sweep, stall, wrap, idle hold.
module tb_mux8way_rr_collector;

  localparam int WIDTH = 16;

  logic               clk;
  logic               rst_n;
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;

  int checks = 0;
  int errors = 0;

  mux8way_rr_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setch(input int i, input logic [WIDTH-1:0] v);
    in_data[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    in_valid = 8'h00;
    rst_n    = 1'b1;

    // single source on ch2
    step();
    in_valid  = 8'b0000_0100;
    setch(2, 16'h1234);
    out_ready = 1'b1;
    #1;
    check("single_in_ready", 32'(in_ready), 32'h04);
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'h1234);
    check("single_sel",   32'(out_sel),   32'd2);
    in_valid = 8'h00;
    #1;
    check("single_no_ready", 32'(in_ready), 32'h00);
    step();
    check("single_drain_valid", 32'(out_valid), 32'd0);
    check("single_hold_data",   32'(out_data),  32'h1234);
    check("single_hold_sel",    32'(out_sel),   32'd2);

    // backpressure: ptr=3, load ch3 then stall with ch5 pending
    in_valid = 8'b0000_1000;
    setch(3, 16'h0303);
    step();
    check("bp_load_sel",  32'(out_sel),  32'd3);
    check("bp_load_data", 32'(out_data), 32'h0303);
    in_valid  = 8'b0010_0000;
    setch(5, 16'h0505);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_stall_ready", 32'(in_ready),  32'h00);
      check("bp_stall_data",  32'(out_data),  32'h0303);
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h20);
    step();
    check("bp_release_sel",  32'(out_sel),  32'd5);
    check("bp_release_data", 32'(out_data), 32'h0505);

    // wrap-around: ptr=6, ch0 and ch3 valid
    in_valid = 8'b0000_1001;
    setch(0, 16'h0A00);
    setch(3, 16'h0A03);
    #1;
    check("wrap_ready0", 32'(in_ready), 32'h01);
    step();
    check("wrap_sel0", 32'(out_sel),  32'd0);
    check("wrap_dat0", 32'(out_data), 32'h0A00);
    in_valid = 8'b0000_1000;
    #1;
    check("wrap_ready3", 32'(in_ready), 32'h08);
    step();
    check("wrap_sel3", 32'(out_sel),  32'd3);
    check("wrap_dat3", 32'(out_data), 32'h0A03);

    // reset mid-stream with 0x00AA held in the output stage
    in_valid = 8'b0000_0010;
    setch(1, 16'h00AA);
    step();
    check("mid_load_data",  32'(out_data),  32'h00AA);
    check("mid_load_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    in_valid  = 8'hFF;
    for (int i = 0; i < 8; i++) setch(i, 16'h0100 + 16'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_sel",   32'(out_sel),   32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'h00);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'h01);

    // full sweep: all valid, sink always ready
    step();
    for (int k = 0; k < 10; k++) begin
      check("sweep_valid", 32'(out_valid), 32'd1);
      check("sweep_sel",   32'(out_sel),   32'(k % 8));
      check("sweep_data",  32'(out_data),  32'h0100 + 32'(k % 8));
      if (k == 9) in_valid = 8'h00;
      step();
    end
    check("sweep_drain", 32'(out_valid), 32'd0);

    // idle cycles must not advance ptr
    in_valid = 8'b0000_0010;
    setch(1, 16'h0601);
    #1;
    check("idle_ready1", 32'(in_ready), 32'h02);
    step();
    check("idle_sel1", 32'(out_sel), 32'd1);
    in_valid = 8'h00;
    repeat (5) step();
    check("idle_empty", 32'(out_valid), 32'd0);
    in_valid = 8'hFF;
    #1;
    check("idle_next_ready", 32'(in_ready), 32'h04);
    step();
    check("idle_next_sel",  32'(out_sel),  32'd2);
    check("idle_next_data", 32'(out_data), 32'h0102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
